// File: rtl/bridge_pkg.sv
// bridge_pkg: FSM state types, fixed AXI IDs and constant AXI attributes for axi_burst_bridge
package bridge_pkg;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wr_state_e;
  localparam int ID_INST = 0;
  localparam int ID_DATA = 1;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] LOCK_NORMAL = 2'b00;
  localparam logic [3:0] CACHE_NONE  = 4'b0000;
  localparam logic [2:0] PROT_NONE   = 3'b000;
endpackage

// File: rtl/axi_wr_channel.sv
// axi_wr_channel: single-beat write FSM driving the AW/W/B handshakes
module axi_wr_channel
  import bridge_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                req,
  input  logic [31:0]         addr,
  input  logic [2:0]          size,
  input  logic [DATA_W/8-1:0] strb_in,
  input  logic [DATA_W-1:0]   data_in,
  output logic                addr_ok,
  output logic                wr_done,
  output logic                idle,
  output logic [ID_W-1:0]     awid,
  output logic [31:0]         awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [ID_W-1:0]     wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready
);
  wr_state_e           w_q, w_d;
  logic                aw_q, aw_d, wv_q, wv_d;
  logic [31:0]         addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [DATA_W/8-1:0] strb_q, strb_d;
  logic [DATA_W-1:0]   data_q, data_d;
  assign idle    = w_q == W_IDLE;
  assign addr_ok = idle && req;
  assign wr_done = w_q == W_RESP && bvalid;
  assign bready  = w_q == W_RESP;
  always_comb begin
    w_d    = w_q;
    aw_d   = aw_q && !awready;
    wv_d   = wv_q && !wready;
    addr_d = addr_q;
    size_d = size_q;
    strb_d = strb_q;
    data_d = data_q;
    if (addr_ok) begin
      w_d    = W_SEND;
      aw_d   = 1'b1;
      wv_d   = 1'b1;
      addr_d = addr;
      size_d = size;
      strb_d = strb_in;
      data_d = data_in;
    end else if (w_q == W_SEND && !aw_d && !wv_d) w_d = W_RESP;
    else if (wr_done) w_d = W_IDLE;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_q    <= W_IDLE;
      aw_q   <= 1'b0;
      wv_q   <= 1'b0;
      addr_q <= '0;
      size_q <= '0;
      strb_q <= '0;
      data_q <= '0;
    end else begin
      w_q    <= w_d;
      aw_q   <= aw_d;
      wv_q   <= wv_d;
      addr_q <= addr_d;
      size_q <= size_d;
      strb_q <= strb_d;
      data_q <= data_d;
    end
  end
  assign awvalid = aw_q;
  assign awid    = aw_q ? ID_W'(ID_DATA) : '0;
  assign awaddr  = addr_q;
  assign awlen   = 4'd0;
  assign awsize  = size_q;
  assign awburst = BURST_INCR;
  assign awlock  = LOCK_NORMAL;
  assign awcache = CACHE_NONE;
  assign awprot  = PROT_NONE;
  assign wvalid  = wv_q;
  assign wid     = wv_q ? ID_W'(ID_DATA) : '0;
  assign wdata   = data_q;
  assign wstrb   = strb_q;
  assign wlast   = wv_q;
endmodule

// File: rtl/axi_burst_bridge.sv
// axi_burst_bridge: arbitrates inst/data SRAM-like ports onto AXI3 with burst reads and an independent write path
module axi_burst_bridge
  import bridge_pkg::*;
#(
  parameter int  ID_W      = 4,
  parameter int  DATA_W    = 32,
  parameter int  MAX_BEATS = 8,
  localparam int LEN_W     = MAX_BEATS > 2 ? $clog2(MAX_BEATS) : 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                inst_req,
  input  logic [31:0]         inst_addr,
  input  logic [LEN_W-1:0]    inst_len,
  output logic                inst_addr_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_rvalid,
  output logic                inst_rlast,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [31:0]         data_addr,
  input  logic [LEN_W-1:0]    data_len,
  input  logic [2:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_rvalid,
  output logic                data_rlast,
  output logic                data_wr_done,
  output logic [ID_W-1:0]     arid,
  output logic [31:0]         araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [ID_W-1:0]     awid,
  output logic [31:0]         awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [ID_W-1:0]     wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);
  localparam logic [2:0] SIZE_FULL = 3'($clog2(DATA_W / 8));
  rd_state_e       r_q, r_d;
  logic            own_q, own_d;
  logic [ID_W-1:0] arid_q, arid_d;
  logic [31:0]     araddr_q, araddr_d;
  logic [3:0]      arlen_q, arlen_d;
  logic [2:0]      arsize_q, arsize_d;
  logic            w_idle, wr_ok, d_acc, i_acc, beat;
  // a data read must not overtake a write still in flight
  assign d_acc = r_q == R_IDLE && data_req && !data_wr && w_idle;
  assign i_acc = r_q == R_IDLE && inst_req && !d_acc;
  assign inst_addr_ok = i_acc;
  assign data_addr_ok = d_acc || wr_ok;
  always_comb begin
    r_d      = r_q;
    own_d    = own_q;
    arid_d   = arid_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    arsize_d = arsize_q;
    if (d_acc || i_acc) begin
      r_d      = R_ADDR;
      own_d    = d_acc;
      arid_d   = d_acc ? ID_W'(ID_DATA) : ID_W'(ID_INST);
      araddr_d = d_acc ? data_addr : inst_addr;
      arlen_d  = 4'(d_acc ? data_len : inst_len);
      arsize_d = d_acc ? data_size : SIZE_FULL;
    end else if (r_q == R_ADDR && arready) r_d = R_DATA;
    else if (r_q == R_DATA && rvalid && rlast) r_d = R_IDLE;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_q      <= R_IDLE;
      own_q    <= 1'b0;
      arid_q   <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      arsize_q <= '0;
    end else begin
      r_q      <= r_d;
      own_q    <= own_d;
      arid_q   <= arid_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      arsize_q <= arsize_d;
    end
  end
  assign arvalid = r_q == R_ADDR;
  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;
  assign arburst = BURST_INCR;
  assign arlock  = LOCK_NORMAL;
  assign arcache = CACHE_NONE;
  assign arprot  = PROT_NONE;
  assign rready  = r_q == R_DATA;
  // beats are routed by the latched owner, never by rid
  assign beat        = rready && rvalid;
  assign inst_rvalid = beat && !own_q;
  assign data_rvalid = beat && own_q;
  assign inst_rlast  = inst_rvalid && rlast;
  assign data_rlast  = data_rvalid && rlast;
  assign inst_rdata  = inst_rvalid ? rdata : '0;
  assign data_rdata  = data_rvalid ? rdata : '0;
  axi_wr_channel #(.ID_W(ID_W), .DATA_W(DATA_W)) u_wr (
    .aclk(aclk), .aresetn(aresetn),
    .req(data_req && data_wr), .addr(data_addr), .size(data_size),
    .strb_in(data_wstrb), .data_in(data_wdata),
    .addr_ok(wr_ok), .wr_done(data_wr_done), .idle(w_idle),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );
endmodule

// File: tb/tb_axi_burst_bridge.sv
// tb_axi_burst_bridge: directed stimulus with scoreboard queues checked by a negedge monitor
module tb_axi_burst_bridge;
  localparam int ID_W = 4, DATA_W = 32, LEN_W = 3;
  logic aclk = 1'b0, aresetn = 1'b0;
  always #5 aclk = ~aclk;
  logic inst_req, inst_addr_ok, inst_rvalid, inst_rlast;
  logic [31:0] inst_addr, inst_rdata;
  logic [LEN_W-1:0] inst_len, data_len;
  logic data_req, data_wr, data_addr_ok, data_rvalid, data_rlast, data_wr_done;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [2:0] data_size;
  logic [3:0] data_wstrb;
  logic [ID_W-1:0] arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [3:0] arlen, arcache, awlen, awcache, wstrb;
  logic [2:0] arsize, arprot, awsize, awprot;
  logic [1:0] arburst, arlock, rresp, awburst, awlock, bresp;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  int n_vec = 0, n_err = 0;
  logic [42:0] arq[$];
  logic [33:0] rq[$];
  logic [34:0] awq[$];
  logic [35:0] wq[$];

  axi_burst_bridge #(.ID_W(ID_W), .DATA_W(DATA_W), .MAX_BEATS(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_len(inst_len), .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid), .inst_rlast(inst_rlast),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_len(data_len),
    .data_size(data_size), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_rvalid(data_rvalid),
    .data_rlast(data_rlast), .data_wr_done(data_wr_done),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: DUT event with no expected entry (or wait expired)", nm);
  endtask

  always @(negedge aclk) if (aresetn) begin
    if (inst_rvalid && data_rvalid) miss("r_both_ports");
    if (inst_rvalid || data_rvalid) begin
      if (rq.size() == 0) miss("rbeat");
      else chk("rbeat", {data_rvalid, data_rvalid ? data_rlast : inst_rlast,
                         data_rvalid ? data_rdata : inst_rdata}, rq.pop_front());
    end
    if (arvalid && arready) begin
      if (arq.size() == 0) miss("ar");
      else chk("ar", {araddr, arlen, arid, arsize}, arq.pop_front());
    end
    if (awvalid && awready) begin
      if (awq.size() == 0) miss("aw");
      else chk("aw", {awaddr, awsize, awlen, awid}, {awq.pop_front(), 8'h01});
    end
    if (wvalid && wready) begin
      if (wq.size() == 0) miss("w");
      else chk("w", {wdata, wstrb, wlast, wid}, {wq.pop_front(), 5'h11});
    end
    if (inst_addr_ok && !inst_req) miss("inst_ok_no_req");
    if (data_addr_ok && !data_req) miss("data_ok_no_req");
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic wait_ok(input bit dport, input string nm);
    for (int i = 0; i < 30; i++) begin
      #1;
      if (dport ? data_addr_ok : inst_addr_ok) begin
        cyc();
        if (dport) begin data_req = 0; data_wr = 0; end
        else inst_req = 0;
        return;
      end
      cyc();
    end
    miss(nm);
    inst_req = 0;
    data_req = 0;
  endtask

  task automatic ar_hs();
    int i = 0;
    while (!arvalid && i < 30) begin cyc(); i++; end
    if (!arvalid) miss("ar_wait");
    arready = 1;
    cyc();
    arready = 0;
  endtask

  task automatic beat(input bit dport, input logic [31:0] d, input bit last, input bit gap);
    if (gap) cyc();
    rvalid = 1; rdata = d; rlast = last;
    rq.push_back({dport, last, d});
    #1 chk("rvalid_same_cycle", dport ? data_rvalid : inst_rvalid, 1);
    cyc();
    rvalid = 0; rlast = 0;
  endtask

  task automatic wr_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    data_req = 1; data_wr = 1; data_addr = a; data_wdata = d; data_wstrb = s; data_size = 3'd2;
    awq.push_back({a, 3'd2});
    wq.push_back({d, s});
    wait_ok(1, "wr_accept");
    chk("wr_valid_c1", {awvalid, wvalid}, 2'b11);
  endtask

  task automatic wr_hs(input int da, input int dw);
    for (int t = 0; t < 4; t++) begin
      awready = t >= da;
      wready = t >= dw;
      cyc();
    end
    awready = 0; wready = 0;
  endtask

  task automatic wr_b();
    chk("wr_done_pre", {bready, data_wr_done}, 2'b10);
    bvalid = 1;
    #1 chk("wr_done", data_wr_done, 1);
    cyc();
    bvalid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    inst_req = 0; inst_addr = 0; inst_len = 0;
    data_req = 0; data_wr = 0; data_addr = 0; data_len = 0; data_size = 0; data_wstrb = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    cyc(3);
    chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready, inst_rvalid, data_rvalid, data_wr_done}, 0);
    chk("rst_addr", {araddr, awaddr}, 0);
    chk("rst_ids", {arid, awid, wid}, 0);
    chk("rst_wdata", wdata, 0);
    aresetn = 1;
    cyc(2);
    // single instruction read
    inst_req = 1; inst_addr = 32'hBFC00000; inst_len = 0;
    arq.push_back({32'hBFC00000, 4'd0, 4'd0, 3'd2});
    #1 chk("t1_addr_ok_c0", inst_addr_ok, 1);
    chk("t1_arvalid_c0", arvalid, 0);
    cyc();
    inst_req = 0;
    chk("t1_arvalid_c1", arvalid, 1);
    ar_hs();
    beat(0, 32'h24010001, 1, 0);
    // 8-beat refill with gaps
    inst_req = 1; inst_addr = 32'h00001000; inst_len = 7;
    arq.push_back({32'h00001000, 4'd7, 4'd0, 3'd2});
    wait_ok(0, "t2_accept");
    ar_hs();
    for (int i = 0; i < 8; i++) beat(0, 32'(i), i == 7, i[0]);
    // simultaneous reads: data first
    inst_req = 1; inst_addr = 32'h00002000; inst_len = 0;
    data_req = 1; data_wr = 0; data_addr = 32'h80001000; data_len = 1; data_size = 3'd2;
    #1 chk("t3_data_ok", data_addr_ok, 1);
    chk("t3_inst_ok", inst_addr_ok, 0);
    arq.push_back({32'h80001000, 4'd1, 4'd1, 3'd2});
    cyc();
    data_req = 0;
    chk("t3_inst_blk1", inst_addr_ok, 0);
    ar_hs();
    beat(1, 32'hA5A50000, 0, 0);
    chk("t3_inst_blk2", inst_addr_ok, 0);
    beat(1, 32'hA5A50001, 1, 1);
    chk("t3_inst_after_last", inst_addr_ok, 1);
    arq.push_back({32'h00002000, 4'd0, 4'd0, 3'd2});
    wait_ok(0, "t3_inst_accept");
    ar_hs();
    beat(0, 32'h11112222, 1, 0);
    // write handshake orderings
    wr_issue(32'h1FAF0000, 32'hDEADBEEF, 4'hF); wr_hs(0, 2); wr_b();
    wr_issue(32'h1FAF0000, 32'hDEADBEEF, 4'hF); wr_hs(2, 0); wr_b();
    wr_issue(32'h1FAF0000, 32'hDEADBEEF, 4'hF); wr_hs(1, 1); wr_b();
    // pending write blocks data read but not inst read
    wr_issue(32'h1FAF0010, 32'hCAFEF00D, 4'h3);
    wr_hs(1, 1);
    data_req = 1; data_wr = 0; data_addr = 32'h80002000; data_len = 0; data_size = 3'd2;
    inst_req = 1; inst_addr = 32'h00003000; inst_len = 0;
    #1 chk("t5_data_blocked", data_addr_ok, 0);
    chk("t5_inst_ok", inst_addr_ok, 1);
    arq.push_back({32'h00003000, 4'd0, 4'd0, 3'd2});
    cyc();
    inst_req = 0;
    chk("t5_data_blocked2", data_addr_ok, 0);
    wr_b();
    ar_hs();
    beat(0, 32'h33330000, 1, 0);
    arq.push_back({32'h80002000, 4'd0, 4'd1, 3'd2});
    wait_ok(1, "t5_data_accept");
    ar_hs();
    beat(1, 32'h44440000, 1, 0);
    // reset during beat 3 of 8
    inst_req = 1; inst_addr = 32'h00004000; inst_len = 7;
    arq.push_back({32'h00004000, 4'd7, 4'd0, 3'd2});
    wait_ok(0, "t6_accept");
    ar_hs();
    for (int i = 0; i < 3; i++) beat(0, 32'h60 + 32'(i), 0, 0);
    rvalid = 1; rdata = 32'h63; rlast = 0;
    #1 chk("t6_beat3_live", inst_rvalid, 1);
    aresetn = 0;
    #1 chk("t6_rst_outs", {inst_rvalid, inst_rdata, rready, arvalid, awvalid, wvalid, inst_addr_ok}, 0);
    chk("t6_rst_araddr", araddr, 0);
    rvalid = 0;
    cyc(2);
    aresetn = 1;
    cyc();
    inst_req = 1; inst_addr = 32'h00005000; inst_len = 1;
    arq.push_back({32'h00005000, 4'd1, 4'd0, 3'd2});
    wait_ok(0, "t6_post_accept");
    ar_hs();
    beat(0, 32'h55550000, 0, 1);
    beat(0, 32'h55550001, 1, 0);
    cyc(3);
    chk("left_r", rq.size(), 0);
    chk("left_ar", arq.size(), 0);
    chk("left_aw", awq.size(), 0);
    chk("left_w", wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
